// File: rtl/fft4_stream.sv
// fft4_stream: streaming 4-point DFT engine.
//
// It collects four signed real samples through a valid/ready input.
// It then evaluates a two-stage radix-2 butterfly in a single registered
// cycle. The four complex bins X[0..3] then leave serially through a
// valid/ready output.
//
// Parameters
//   DATA_W  input sample width, signed two's complement (>= 2)
//   FCNT_W  width of the completed-frame counter
//   OUT_W   DATA_W+2 (derived, not overridable); holds 4*(-2^(DATA_W-1)) exactly
//
// Ports
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready    sample handshake; in_data = x[k], k = 0..3 in order
//   inverse              (only with FFT4_IFFT_EN) sampled on the first accept
//                        of a frame; 1 negates the X1/X3 imaginary parts
//   out_valid/out_ready  bin handshake
//   out_re/out_im        signed real/imaginary part of X[m]
//   out_idx/out_last     bin index m, high with bin 3
//   frame_cnt            frames fully emitted, wraps silently
//
// Configuration macro: FFT4_IFFT_EN (default undefined = forward DFT only).
module fft4_stream #(
  parameter  int DATA_W = 4,
  parameter  int FCNT_W = 8,
  localparam int OUT_W  = DATA_W + 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
`ifdef FFT4_IFFT_EN
  input  logic                    inverse,
`endif
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_re,
  output logic signed [OUT_W-1:0] out_im,
  output logic [1:0]              out_idx,
  output logic                    out_last,
  output logic [FCNT_W-1:0]       frame_cnt
);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_CALC = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t                  state_r;
  logic [1:0]              cnt_r;
  logic [DATA_W-1:0]       samp_r   [4];
  logic signed [OUT_W-1:0] bin_re_r [4];
  logic signed [OUT_W-1:0] bin_im_r [4];

  logic                    inv_s;
  logic signed [OUT_W-1:0] xe_s      [4];
  logic signed [OUT_W-1:0] sum02_s;
  logic signed [OUT_W-1:0] sum13_s;
  logic signed [OUT_W-1:0] dif02_s;
  logic signed [OUT_W-1:0] dif31_s;
  logic signed [OUT_W-1:0] im1_s;
  logic signed [OUT_W-1:0] calc_re_s [4];
  logic signed [OUT_W-1:0] calc_im_s [4];
  logic [1:0]              nxt_idx_s;

`ifdef FFT4_IFFT_EN
  logic inv_r;
  assign inv_s = inv_r;
`else
  assign inv_s = 1'b0;
`endif

  assign nxt_idx_s = out_idx + 2'd1;

  // Butterfly: sign-extend the stored frame, share the x0+/-x2 and x1/x3 terms.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      xe_s[i] = {{(OUT_W - DATA_W){samp_r[i][DATA_W-1]}}, samp_r[i]};
    end
    sum02_s = xe_s[0] + xe_s[2];
    sum13_s = xe_s[1] + xe_s[3];
    dif02_s = xe_s[0] - xe_s[2];
    dif31_s = xe_s[3] - xe_s[1];
    // Conjugated twiddles flip the sign of the odd-bin imaginary parts.
    if (inv_s) begin
      im1_s = -dif31_s;
    end else begin
      im1_s = dif31_s;
    end
    calc_re_s[0] = sum02_s + sum13_s;
    calc_im_s[0] = {OUT_W{1'b0}};
    calc_re_s[1] = dif02_s;
    calc_im_s[1] = im1_s;
    calc_re_s[2] = sum02_s - sum13_s;
    calc_im_s[2] = {OUT_W{1'b0}};
    calc_re_s[3] = dif02_s;
    calc_im_s[3] = -im1_s;
  end

  // Frame FSM: load four samples, compute once, emit four bins under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= S_LOAD;
      cnt_r     <= 2'd0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_re    <= {OUT_W{1'b0}};
      out_im    <= {OUT_W{1'b0}};
      out_idx   <= 2'd0;
      out_last  <= 1'b0;
      frame_cnt <= {FCNT_W{1'b0}};
`ifdef FFT4_IFFT_EN
      inv_r     <= 1'b0;
`endif
      for (int i = 0; i < 4; i++) begin
        samp_r[i]   <= {DATA_W{1'b0}};
        bin_re_r[i] <= {OUT_W{1'b0}};
        bin_im_r[i] <= {OUT_W{1'b0}};
      end
    end else begin
      case (state_r)
        S_LOAD: begin
          if (in_valid && in_ready) begin
            samp_r[cnt_r] <= in_data;
            cnt_r         <= cnt_r + 2'd1;
`ifdef FFT4_IFFT_EN
            if (cnt_r == 2'd0) begin
              inv_r <= inverse;
            end
`endif
            if (cnt_r == 2'd3) begin
              state_r  <= S_CALC;
              in_ready <= 1'b0;
            end
          end
        end
        S_CALC: begin
          for (int i = 0; i < 4; i++) begin
            bin_re_r[i] <= calc_re_s[i];
            bin_im_r[i] <= calc_im_s[i];
          end
          // Bin 0 goes straight to the output registers so it is valid next cycle.
          out_re    <= calc_re_s[0];
          out_im    <= calc_im_s[0];
          out_idx   <= 2'd0;
          out_last  <= 1'b0;
          out_valid <= 1'b1;
          state_r   <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            if (out_last) begin
              state_r   <= S_LOAD;
              in_ready  <= 1'b1;
              out_valid <= 1'b0;
              out_re    <= {OUT_W{1'b0}};
              out_im    <= {OUT_W{1'b0}};
              out_idx   <= 2'd0;
              out_last  <= 1'b0;
              frame_cnt <= frame_cnt + {{(FCNT_W - 1){1'b0}}, 1'b1};
            end else begin
              out_re   <= bin_re_r[nxt_idx_s];
              out_im   <= bin_im_r[nxt_idx_s];
              out_idx  <= nxt_idx_s;
              out_last <= (nxt_idx_s == 2'd3);
            end
          end
        end
        default: begin
          state_r   <= S_LOAD;
          cnt_r     <= 2'd0;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft4_stream.sv
`timescale 1ns/1ps
module tb_fft4_stream;
  localparam int DATA_W = 4;
  localparam int OUT_W  = DATA_W + 2;
  localparam int FCNT_W = 8;

  typedef int arr4_t [4];
  typedef struct {
    arr4_t x;
    bit    inv;
    arr4_t re;
    arr4_t im;
  } vec_t;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic [DATA_W-1:0]       in_data = '0;
`ifdef FFT4_IFFT_EN
  logic                    inverse = 1'b0;
`endif
  logic                    out_valid;
  logic                    out_ready = 1'b1;
  logic signed [OUT_W-1:0] out_re;
  logic signed [OUT_W-1:0] out_im;
  logic [1:0]              out_idx;
  logic                    out_last;
  logic [FCNT_W-1:0]       frame_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int exp_fcnt = 0;
  bit inv_sel  = 1'b0;

  fft4_stream #(.DATA_W(DATA_W), .FCNT_W(FCNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
`ifdef FFT4_IFFT_EN
    .inverse(inverse),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .out_re(out_re), .out_im(out_im), .out_idx(out_idx),
    .out_last(out_last), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference DFT straight from the definition X[m] = sum x[k] * W^(mk), W = -j.
  function automatic void dft_ref(input arr4_t x, input bit inv, output arr4_t re, output arr4_t im);
    for (int m = 0; m < 4; m++) begin
      re[m] = 0;
      im[m] = 0;
      for (int k = 0; k < 4; k++) begin
        case ((m * k) % 4)
          0: re[m] += x[k];
          1: im[m] -= x[k];
          2: re[m] -= x[k];
          default: im[m] += x[k];
        endcase
      end
      if (inv) im[m] = -im[m];
    end
  endfunction

  function automatic vec_t mk(input arr4_t x, input bit inv, input arr4_t re, input arr4_t im);
    vec_t v;
    v.x = x; v.inv = inv; v.re = re; v.im = im;
    return v;
  endfunction

  task automatic push_frame(input arr4_t x, input int max_gap);
    int guard;
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(0, max_gap)) begin
        in_valid = 1'b0;
        in_data  = DATA_W'($urandom);
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = DATA_W'(x[k]);
`ifdef FFT4_IFFT_EN
      // Only the first sample's inverse value may matter.
      inverse = (k == 0) ? inv_sel : !inv_sel;
`endif
      guard = 0;
      while (!in_ready && guard < 40) begin @(posedge clk); #1; guard++; end
      if (!in_ready) begin
        check("in_ready_timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("calc_out_valid", out_valid, 0);
    check("calc_in_ready", in_ready, 0);
  endtask

  task automatic pull_frame(input arr4_t er, input arr4_t ei, input int stall_idx,
                            input int stall_n, input bit junk, input string tag);
    int waited = 0;
    while (!out_valid && waited < 20) begin @(posedge clk); #1; waited++; end
    check({tag, "_latency"}, waited, 1);
    if (!out_valid) return;
    for (int m = 0; m < 4; m++) begin
      if (junk) begin
        in_valid = 1'b1;
        in_data  = DATA_W'($urandom);
      end
      check($sformatf("%s_re%0d", tag, m), out_re, er[m]);
      check($sformatf("%s_im%0d", tag, m), out_im, ei[m]);
      check($sformatf("%s_idx%0d", tag, m), out_idx, m);
      check($sformatf("%s_last%0d", tag, m), out_last, (m == 3) ? 1 : 0);
      check($sformatf("%s_vld%0d", tag, m), out_valid, 1);
      check($sformatf("%s_inrdy%0d", tag, m), in_ready, 0);
      if (m == stall_idx) begin
        out_ready = 1'b0;
        repeat (stall_n) begin
          @(posedge clk); #1;
          check({tag, "_hold_re"}, out_re, er[m]);
          check({tag, "_hold_im"}, out_im, ei[m]);
          check({tag, "_hold_idx"}, out_idx, m);
          check({tag, "_hold_vld"}, out_valid, 1);
          check({tag, "_hold_inrdy"}, in_ready, 0);
        end
        out_ready = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    exp_fcnt = (exp_fcnt + 1) % (1 << FCNT_W);
    check({tag, "_end_vld"}, out_valid, 0);
    check({tag, "_end_inrdy"}, in_ready, 1);
    check({tag, "_fcnt"}, frame_cnt, exp_fcnt);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_vld"}, out_valid, 0);
    check({tag, "_re"}, out_re, 0);
    check({tag, "_im"}, out_im, 0);
    check({tag, "_idx"}, out_idx, 0);
    check({tag, "_last"}, out_last, 0);
    check({tag, "_fcnt"}, frame_cnt, 0);
  endtask

  initial begin
    vec_t  tbl[$];
    arr4_t x, rr, ri;
    arr4_t ramp_x, ramp_re, ramp_im, imp_x, ones;

    ramp_x  = '{1, 2, 3, 4};
    ramp_re = '{10, -2, -2, -2};
    ramp_im = '{0, 2, 0, -2};
    imp_x   = '{1, 0, 0, 0};
    ones    = '{1, 1, 1, 1};

    tbl.push_back(mk(imp_x, 1'b0, ones, '{0, 0, 0, 0}));
    tbl.push_back(mk(ones, 1'b0, '{4, 0, 0, 0}, '{0, 0, 0, 0}));
    tbl.push_back(mk(ramp_x, 1'b0, ramp_re, ramp_im));
    tbl.push_back(mk('{-8, -8, -8, -8}, 1'b0, '{-32, 0, 0, 0}, '{0, 0, 0, 0}));
    tbl.push_back(mk('{7, -8, 7, -8}, 1'b0, '{-2, 0, 30, 0}, '{0, 0, 0, 0}));
    tbl.push_back(mk('{-8, 0, 7, 0}, 1'b0, '{-1, -15, -1, -15}, '{0, 0, 0, 0}));
    tbl.push_back(mk('{0, -8, 0, 7}, 1'b0, '{-1, 0, 1, 0}, '{0, 15, 0, -15}));
`ifdef FFT4_IFFT_EN
    tbl.push_back(mk(ramp_x, 1'b1, ramp_re, '{0, -2, 0, 2}));
    tbl.push_back(mk(ramp_x, 1'b0, ramp_re, ramp_im));
`endif

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    check("reset_inrdy", in_ready, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_inrdy", in_ready, 1);
    check("post_reset_vld", out_valid, 0);

    // Directed table
    foreach (tbl[i]) begin
      inv_sel = tbl[i].inv;
      push_frame(tbl[i].x, 0);
      pull_frame(tbl[i].re, tbl[i].im, -1, 0, 1'b0, $sformatf("tbl%0d", i));
    end
    inv_sel = 1'b0;

    // Backpressure on bin 1 with junk input offered meanwhile
    push_frame(ramp_x, 0);
    pull_frame(ramp_re, ramp_im, 1, 5, 1'b1, "bp");

    // Reset after two samples of a frame
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1;
      in_data  = DATA_W'(k + 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_zero("rstA");
    check("rstA_inrdy", in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_fcnt = 0;
    @(posedge clk); #1;
    check("rstA_rel_inrdy", in_ready, 1);
    push_frame(ramp_x, 0);
    pull_frame(ramp_re, ramp_im, -1, 0, 1'b0, "rstA_next");

    // Reset after bin 1 of a later frame
    push_frame(ones, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rstB_pre_idx", out_idx, 2);
    rst_n = 1'b0;
    #1;
    check_zero("rstB");
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_fcnt = 0;
    @(posedge clk); #1;
    check("rstB_rel_inrdy", in_ready, 1);
    push_frame(imp_x, 0);
    pull_frame(ones, '{0, 0, 0, 0}, -1, 0, 1'b0, "rstB_next");

    // Random frames against the reference model; enough to wrap frame_cnt
    for (int f = 0; f < 260; f++) begin
      for (int k = 0; k < 4; k++) x[k] = int'($urandom_range(0, 15)) - 8;
`ifdef FFT4_IFFT_EN
      inv_sel = 1'($urandom_range(0, 1));
`else
      inv_sel = 1'b0;
`endif
      dft_ref(x, inv_sel, rr, ri);
      push_frame(x, 2);
      pull_frame(rr, ri, int'($urandom_range(0, 4)), int'($urandom_range(1, 3)),
                 1'($urandom_range(0, 1)), "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
